cpu_sequencer: RTL and testbench
================================

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 The block SHALL have clk, input, 1, the single clock; all state changes on its rising edge.
REQ-002 The block SHALL have rst_n, input, 1, asynchronous active-low reset.
REQ-003 The block SHALL have run, input, 1; while high, the block starts new instructions.
REQ-004 The block SHALL have imem_req (out, 1), imem_addr (out, 32), imem_ack (in, 1) and imem_rdata (in, 32) as the instruction-fetch handshake.
REQ-005 The block SHALL have instr (out, 32), the latched instruction presented to the decoder.
REQ-006 The block SHALL have dec_enable (out, 1), dec_valid (in, 1), dec_mem_read (in, 1) and dec_mem_write (in, 1) as the decoder control/status lines.
REQ-007 The block SHALL have exe_enable (out, 1), a one-cycle ALU/address-generation strobe.
REQ-008 The block SHALL have dmem_req (out, 1), dmem_we (out, 1) and dmem_ack (in, 1) as the data-memory handshake.
REQ-009 The block SHALL have rf_we (out, 1), a one-cycle register-file write strobe.
REQ-010 The block SHALL have pc (out, 32), the address of the current instruction.
REQ-011 The block SHALL have nzcv (in, 4), the current condition flags.
REQ-012 The block SHALL have busy (out, 1), high in every state except IDLE.

Function
REQ-013 The FSM SHALL have the states IDLE, FETCH, DECODE, DEC_WAIT, EXECUTE, MEMORY, WRITEBACK.
REQ-014 In IDLE, the FSM SHALL go to FETCH when run=1, else stay in IDLE.
REQ-015 In FETCH, imem_req=1 and imem_addr=pc SHALL hold until imem_ack; on ack, instr SHALL latch imem_rdata and the FSM SHALL go to DECODE.
REQ-016 DECODE SHALL assert dec_enable for exactly one cycle and then go to DEC_WAIT.
REQ-017 DEC_WAIT SHALL last one cycle; if dec_valid=0 the FSM SHALL skip the instruction (pc+4, to IDLE/FETCH per REQ-022), else go to EXECUTE.
REQ-018 EXECUTE SHALL assert exe_enable for one cycle, then go to MEMORY if dec_mem_read or dec_mem_write, else to WRITEBACK.
REQ-019 In MEMORY, dmem_req=1 and dmem_we=dec_mem_write SHALL hold until dmem_ack, then the FSM SHALL go to WRITEBACK; there is no timeout.
REQ-020 In WRITEBACK, rf_we SHALL be 1 for data-processing (instr[27:26]=00), loads, and branch-with-link (instr[27:25]=101, instr[24]=1); otherwise rf_we SHALL be 0.
REQ-021 In WRITEBACK, pc SHALL update to pc+8+(sign-extended instr[23:0] shifted left 2) for branches (instr[27:25]=101), else to pc+4; arithmetic SHALL be 32-bit modulo, so wrap at 0xFFFFFFFC to 0x00000000 is legal.
REQ-022 After WRITEBACK or a skip, the FSM SHALL go to FETCH if run=1, else to IDLE; run deassertion mid-instruction SHALL NOT abort the instruction.
REQ-023 dec_enable, exe_enable and rf_we SHALL each be registered one-cycle pulses and mutually exclusive.
REQ-024 Minimum latency for a non-memory instruction with zero-wait imem_ack SHALL be 5 cycles from FETCH entry to the next FETCH entry.

Reset
REQ-025 rst_n low SHALL force, asynchronously, state=IDLE, pc=0, instr=0, and all request/strobe outputs=0, in any state including mid-handshake.
REQ-026 After rst_n rises, the first FETCH SHALL use imem_addr=0.

Configuration
REQ-027 With CPU_SEQ_COND_CHECK_EN defined, DEC_WAIT SHALL evaluate instr[31:28] against nzcv (EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL; 1111 treated as never); on fail the instruction SHALL be skipped as in REQ-017 with no exe_enable, dmem_req or rf_we.
REQ-028 Without CPU_SEQ_COND_CHECK_EN, every valid instruction SHALL execute regardless of instr[31:28] and nzcv, and nzcv SHALL be ignored.

Verification
REQ-029 Reset, run=1, imem_rdata=0xE0812003 (ADD), immediate ack -> imem_addr=0; dec_enable, exe_enable and rf_we each pulse once; next fetch at 0x4 after 5 cycles.
REQ-030 LDR 0xE5912000 with dmem_ack delayed 3 cycles -> dmem_req high 3 cycles with dmem_we=0; rf_we pulses after ack; pc=0x4.
REQ-031 STR 0xE5812000 -> dmem_we=1 during MEMORY; rf_we stays 0.
REQ-032 BL 0xEBFFFFFE at pc=0x100 -> rf_we=1; pc=0x100.
REQ-033 With CPU_SEQ_COND_CHECK_EN, BEQ 0x0A000001 and nzcv=0000 -> skipped, no exe_enable, pc=+4; with nzcv=0100 -> pc=+12.
REQ-034 Assert rst_n low during MEMORY with dmem_req high -> dmem_req drops immediately; state=IDLE; pc=0.

Source files
------------

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle instruction sequencer.
// Walks each instruction through FETCH, DECODE, DEC_WAIT, EXECUTE, optional
// MEMORY and WRITEBACK, driving the fetch/decode/execute/data-memory/register-
// file handshakes and maintaining the program counter.
// Optional feature macro: CPU_SEQ_COND_CHECK_EN -- when defined, DEC_WAIT
// checks the instruction condition field against nzcv and skips on failure.
module cpu_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        dec_enable,
  input  logic        dec_valid,
  input  logic        dec_mem_read,
  input  logic        dec_mem_write,
  output logic        exe_enable,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        rf_we,
  output logic [31:0] pc,
  input  logic [3:0]  nzcv,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    DEC_WAIT,
    EXECUTE,
    MEMORY,
    WRITEBACK
  } state_t;

  state_t      state;
  state_t      next_state;
  logic        cond_ok;
  logic        mem_read_q;
  logic        is_branch;
  logic        wb_writes_rf;
  logic [31:0] branch_offset;
  logic        imem_req_d;
  logic        dec_enable_d;
  logic        exe_enable_d;
  logic        dmem_req_d;
  logic        dmem_we_d;
  logic        rf_we_d;

  assign imem_addr     = pc;
  assign busy          = (state != IDLE);
  assign is_branch     = (instr[27:25] == 3'b101);
  assign branch_offset = {{6{instr[23]}}, instr[23:0], 2'b00};

  // Loads are only known once MEMORY is reached, so the latched read flag is
  // qualified with the state that hands over to WRITEBACK.
  assign wb_writes_rf  = (instr[27:26] == 2'b00)
                       || ((state == MEMORY) && mem_read_q)
                       || (is_branch && instr[24]);

`ifdef CPU_SEQ_COND_CHECK_EN
  logic flag_n;
  logic flag_z;
  logic flag_c;
  logic flag_v;

  assign flag_n = nzcv[3];
  assign flag_z = nzcv[2];
  assign flag_c = nzcv[1];
  assign flag_v = nzcv[0];

  // Evaluate the condition field of the latched instruction against the flags
  always_comb begin
    cond_ok = 1'b0;
    case (instr[31:28])
      4'h0:    cond_ok = flag_z;
      4'h1:    cond_ok = !flag_z;
      4'h2:    cond_ok = flag_c;
      4'h3:    cond_ok = !flag_c;
      4'h4:    cond_ok = flag_n;
      4'h5:    cond_ok = !flag_n;
      4'h6:    cond_ok = flag_v;
      4'h7:    cond_ok = !flag_v;
      4'h8:    cond_ok = flag_c && !flag_z;
      4'h9:    cond_ok = !flag_c || flag_z;
      4'hA:    cond_ok = (flag_n == flag_v);
      4'hB:    cond_ok = (flag_n != flag_v);
      4'hC:    cond_ok = !flag_z && (flag_n == flag_v);
      4'hD:    cond_ok = flag_z || (flag_n != flag_v);
      4'hE:    cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  end
`else
  logic unused_nzcv;

  assign cond_ok     = 1'b1;
  assign unused_nzcv = ^nzcv;
`endif

  // Next-state selection plus the next values of the registered strobes
  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (run) next_state = FETCH;
      FETCH:     if (imem_ack) next_state = DECODE;
      DECODE:    next_state = DEC_WAIT;
      DEC_WAIT: begin
        if (dec_valid && cond_ok) next_state = EXECUTE;
        else                      next_state = run ? FETCH : IDLE;
      end
      EXECUTE:   next_state = (dec_mem_read || dec_mem_write) ? MEMORY : WRITEBACK;
      MEMORY:    if (dmem_ack) next_state = WRITEBACK;
      WRITEBACK: next_state = run ? FETCH : IDLE;
      default:   next_state = IDLE;
    endcase

    imem_req_d   = (next_state == FETCH);
    dec_enable_d = (next_state == DECODE);
    exe_enable_d = (next_state == EXECUTE);
    dmem_req_d   = (next_state == MEMORY);
    dmem_we_d    = (next_state == MEMORY)
                 && ((state == EXECUTE) ? dec_mem_write : dmem_we);
    rf_we_d      = (next_state == WRITEBACK) && wb_writes_rf;
  end

  // State register and registered strobes, all cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      imem_req   <= 1'b0;
      dec_enable <= 1'b0;
      exe_enable <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      rf_we      <= 1'b0;
    end else begin
      state      <= next_state;
      imem_req   <= imem_req_d;
      dec_enable <= dec_enable_d;
      exe_enable <= exe_enable_d;
      dmem_req   <= dmem_req_d;
      dmem_we    <= dmem_we_d;
      rf_we      <= rf_we_d;
    end
  end

  // Instruction latch, load flag capture and program counter advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr      <= 32'd0;
      pc         <= 32'd0;
      mem_read_q <= 1'b0;
    end else begin
      if ((state == FETCH) && imem_ack) instr <= imem_rdata;
      if (state == EXECUTE) mem_read_q <= dec_mem_read;
      if ((state == DEC_WAIT) && !(dec_valid && cond_ok)) begin
        pc <= pc + 32'd4;
      end else if (state == WRITEBACK) begin
        pc <= is_branch ? (pc + 32'd8 + branch_offset) : (pc + 32'd4);
      end
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: directed self-checking bench for cpu_sequencer with a
// scoreboard of expected per-instruction results.
module tb_cpu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        dec_enable;
  logic        dec_valid;
  logic        dec_mem_read;
  logic        dec_mem_write;
  logic        exe_enable;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ack;
  logic        rf_we;
  logic [31:0] pc;
  logic [3:0]  nzcv;
  logic        busy;

  int          errors = 0;
  int          checks = 0;
  int          cycle  = 0;
  logic [31:0] model_pc;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] next_pc;
    logic        exp_rf;
    logic        exp_exe;
    int          exp_dreq;
  } exp_t;

  exp_t sb[$];

  cpu_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .run           (run),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .instr         (instr),
    .dec_enable    (dec_enable),
    .dec_valid     (dec_valid),
    .dec_mem_read  (dec_mem_read),
    .dec_mem_write (dec_mem_write),
    .exe_enable    (exe_enable),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_ack      (dmem_ack),
    .rf_we         (rf_we),
    .pc            (pc),
    .nzcv          (nzcv),
    .busy          (busy)
  );

  // Free-running clock, 10 time units per period
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cycle++;
  endtask

  // Runs one instruction through the DUT, answering the fetch and data
  // handshakes; expectations go into the scoreboard before any stimulus.
  task automatic apply_stimulus(input logic [31:0] word, input logic valid, input logic rd,
                                input logic wr, input int iwait, input int dwait,
                                input logic [31:0] next_pc, input logic exp_rf,
                                input logic exp_exe, input int exp_dreq,
                                input logic drop_run, output int latency);
    exp_t e;
    int   dec_n;
    int   exe_n;
    int   rf_n;
    int   dreq_n;
    int   start;
    logic seen;
    dec_n  = 0;
    exe_n  = 0;
    rf_n   = 0;
    dreq_n = 0;
    seen   = 1'b0;
    e.addr     = model_pc;
    e.next_pc  = next_pc;
    e.exp_rf   = exp_rf;
    e.exp_exe  = exp_exe;
    e.exp_dreq = exp_dreq;
    sb.push_back(e);
    dec_valid     = valid;
    dec_mem_read  = rd;
    dec_mem_write = wr;
    for (int i = 0; i < 10 && !imem_req; i++) step();
    check_output("fetch_req", {31'd0, imem_req}, 32'd1);
    e = sb.pop_front();
    check_output("fetch_addr", imem_addr, e.addr);
    start = cycle;
    for (int i = 0; i < iwait; i++) begin
      step();
      check_output("fetch_hold", {31'd0, imem_req}, 32'd1);
    end
    imem_rdata = word;
    imem_ack   = 1'b1;
    step();
    imem_ack   = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    if (drop_run) run = 1'b0;
    check_output("instr_latch", instr, word);
    for (int i = 0; i < 40; i++) begin
      if (imem_req || !busy) begin
        seen = 1'b1;
        break;
      end
      if (dec_enable) dec_n++;
      if (exe_enable) exe_n++;
      if (rf_we) rf_n++;
      check_output("strobe_excl", {31'd0, $onehot0({dec_enable, exe_enable, rf_we})}, 32'd1);
      if (dmem_req) begin
        dreq_n++;
        check_output("dmem_we", {31'd0, dmem_we}, {31'd0, wr});
        dmem_ack = (dreq_n == dwait);
      end else begin
        dmem_ack = 1'b0;
      end
      step();
    end
    dmem_ack = 1'b0;
    latency  = cycle - start;
    check_output("instr_done", {31'd0, seen}, 32'd1);
    check_output("dec_pulses", dec_n, 32'd1);
    check_output("exe_pulses", exe_n, {31'd0, e.exp_exe});
    check_output("rf_pulses", rf_n, {31'd0, e.exp_rf});
    check_output("dmem_cycles", dreq_n, e.exp_dreq);
    check_output("next_pc", pc, e.next_pc);
    model_pc = e.next_pc;
  endtask

  initial begin
    int          lat;
    logic [31:0] tgt_off;
    logic [31:0] b_word;
    logic [31:0] beq_pc;

    rst_n         = 1'b0;
    run           = 1'b0;
    imem_ack      = 1'b0;
    imem_rdata    = 32'd0;
    dec_valid     = 1'b0;
    dec_mem_read  = 1'b0;
    dec_mem_write = 1'b0;
    dmem_ack      = 1'b0;
    nzcv          = 4'b0000;
    model_pc      = 32'd0;

    repeat (2) step();
    check_output("rst_busy", {31'd0, busy}, 32'd0);
    check_output("rst_pc", pc, 32'd0);
    check_output("rst_instr", instr, 32'd0);
    check_output("rst_imem_req", {31'd0, imem_req}, 32'd0);
    check_output("rst_strobes", {28'd0, dec_enable, exe_enable, rf_we, dmem_req}, 32'd0);
    rst_n = 1'b1;
    step();
    check_output("idle_no_run", {31'd0, busy}, 32'd0);
    run = 1'b1;

    // ADD with instant fetch ack: five-cycle loop
    apply_stimulus(32'hE081_2003, 1, 0, 0, 0, 0, 32'h0000_0004, 1, 1, 0, 0, lat);
    check_output("add_latency", lat, 32'd5);

    // LDR with slow fetch and three-cycle data access
    apply_stimulus(32'hE591_2000, 1, 1, 0, 2, 3, 32'h0000_0008, 1, 1, 3, 0, lat);

    // STR: write enable during MEMORY, no register write
    apply_stimulus(32'hE581_2000, 1, 0, 1, 0, 1, 32'h0000_000C, 0, 1, 1, 0, lat);

    // Decoder rejects the word: skipped
    apply_stimulus(32'hE7F0_00F0, 0, 0, 0, 0, 0, 32'h0000_0010, 0, 0, 0, 0, lat);

    // BEQ with Z clear
    nzcv   = 4'b0000;
    beq_pc = model_pc;
`ifdef CPU_SEQ_COND_CHECK_EN
    apply_stimulus(32'h0A00_0001, 1, 0, 0, 0, 0, beq_pc + 32'd4, 0, 0, 0, 0, lat);
`else
    apply_stimulus(32'h0A00_0001, 1, 0, 0, 0, 0, beq_pc + 32'd12, 0, 1, 0, 0, lat);
`endif

    // BEQ with Z set: taken in every build
    nzcv   = 4'b0100;
    beq_pc = model_pc;
    apply_stimulus(32'h0A00_0001, 1, 0, 0, 0, 0, beq_pc + 32'd12, 0, 1, 0, 0, lat);
    nzcv   = 4'b0000;

    // Branch forward to 0x100
    tgt_off = 32'h0000_0100 - model_pc - 32'd8;
    b_word  = {8'hEA, tgt_off[25:2]};
    apply_stimulus(b_word, 1, 0, 0, 0, 0, 32'h0000_0100, 0, 1, 0, 0, lat);

    // BL to itself: link write, pc unchanged
    apply_stimulus(32'hEBFF_FFFE, 1, 0, 0, 0, 0, 32'h0000_0100, 1, 1, 0, 0, lat);

    // Branch backwards to the top of the address space
    apply_stimulus(32'hEAFF_FFBD, 1, 0, 0, 0, 0, 32'hFFFF_FFFC, 0, 1, 0, 0, lat);

    // ADD at 0xFFFFFFFC wraps to 0; run dropped mid-instruction completes it
    apply_stimulus(32'hE081_2003, 1, 0, 0, 0, 0, 32'h0000_0000, 1, 1, 0, 1, lat);
    check_output("run_drop_idle", {31'd0, busy}, 32'd0);

    run = 1'b1;
    apply_stimulus(32'hE081_2003, 1, 0, 0, 0, 0, 32'h0000_0004, 1, 1, 0, 0, lat);

    // LDR stalled in MEMORY, then asynchronous reset
    dec_valid    = 1'b1;
    dec_mem_read = 1'b1;
    for (int i = 0; i < 10 && !imem_req; i++) step();
    check_output("mem_rst_fetch", imem_addr, 32'h0000_0004);
    imem_rdata = 32'hE591_2000;
    imem_ack   = 1'b1;
    step();
    imem_ack   = 1'b0;
    for (int i = 0; i < 10 && !dmem_req; i++) step();
    check_output("mem_rst_req", {31'd0, dmem_req}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("async_dmem_req", {31'd0, dmem_req}, 32'd0);
    check_output("async_busy", {31'd0, busy}, 32'd0);
    check_output("async_pc", pc, 32'd0);
    check_output("async_instr", instr, 32'd0);
    step();
    rst_n        = 1'b1;
    dec_mem_read = 1'b0;
    model_pc     = 32'd0;

    // First fetch after reset comes from address 0
    apply_stimulus(32'hE081_2003, 1, 0, 0, 0, 0, 32'h0000_0004, 1, 1, 0, 1, lat);
    check_output("sb_empty", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
